// File: rtl/seg_time_decoder.sv
// rtl/seg_time_decoder.sv - recovers binary time from three two-digit seven-segment display words
// Filters bus transitions for stability, range-checks each field, flags faults and classifies updates.
module seg_time_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [13:0]      hrsSeg,
    input  logic [13:0]      minsSeg,
    input  logic [13:0]      secsSeg,
    output logic [5:0]       hour,
    output logic [5:0]       min,
    output logic [5:0]       sec,
    output logic             valid,
    output logic             tick,
    output logic             jump,
    output logic             fault,
    output logic [2:0]       err_field,
    output logic [ERR_W-1:0] err_count
);
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED, FAULT} state_t;

    // Active-low a..g in bits 0..6; result is {legal, digit}.
    function automatic logic [4:0] dec_digit(input logic [6:0] code);
        logic [4:0] r;
        case (code)
            7'b1000000: r = {1'b1, 4'd0};
            7'b1111001: r = {1'b1, 4'd1};
            7'b0100100: r = {1'b1, 4'd2};
            7'b0110000: r = {1'b1, 4'd3};
            7'b0011001: r = {1'b1, 4'd4};
            7'b0010010: r = {1'b1, 4'd5};
            7'b0000010: r = {1'b1, 4'd6};
            7'b1111000: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0011000: r = {1'b1, 4'd9};
            default:    r = 5'd0;
        endcase
        return r;
    endfunction

    // Result is {legal, value}; legal requires both digits valid and the field in range.
    function automatic logic [7:0] dec_field(input logic [13:0] w, input logic [3:0] max_tens,
                                             input logic [6:0] max_val);
        logic [4:0] t;
        logic [4:0] o;
        logic [6:0] v;
        t = dec_digit(w[13:7]);
        o = dec_digit(w[6:0]);
        v = 7'(t[3:0]) * 7'd10 + 7'(o[3:0]);
        return {t[4] && o[4] && (t[3:0] <= max_tens) && (v <= max_val), v};
    endfunction

    state_t           state_q, state_d;
    logic [41:0]      snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic             valid_q, valid_d, tick_q, tick_d, jump_q, jump_d, fault_q, fault_d;
    logic [2:0]       err_field_q, err_field_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [41:0] in_w;
    logic [7:0]  h_f, m_f, s_f;
    logic [2:0]  bad;
    logic [5:0]  nh, nm, ns;

    assign in_w = {hrsSeg, minsSeg, secsSeg};
    assign h_f  = dec_field(snap_q[41:28], 4'd2, 7'd23);
    assign m_f  = dec_field(snap_q[27:14], 4'd5, 7'd59);
    assign s_f  = dec_field(snap_q[13:0],  4'd5, 7'd59);
    assign bad  = {~h_f[7], ~m_f[7], ~s_f[7]};

    // Committed time plus one second, used to tell a tick from a jump.
    always_comb begin
        ns = sec_q + 6'd1;
        nm = min_q;
        nh = hour_q;
        if (sec_q == 6'd59) begin
            ns = 6'd0;
            nm = min_q + 6'd1;
            if (min_q == 6'd59) begin
                nm = 6'd0;
                nh = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        cnt_d       = cnt_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        valid_d     = valid_q;
        fault_d     = fault_q;
        err_field_d = err_field_q;
        err_count_d = err_count_q;
        tick_d      = 1'b0;
        jump_d      = 1'b0;
        if (in_w != snap_q) begin
            snap_d  = in_w;
            cnt_d   = '0;
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
                if (bad == 3'b000) begin
                    hour_d  = h_f[5:0];
                    min_d   = m_f[5:0];
                    sec_d   = s_f[5:0];
                    valid_d = 1'b1;
                    fault_d = 1'b0;
                    state_d = LOCKED;
                    if (valid_q) begin
                        if ({h_f[5:0], m_f[5:0], s_f[5:0]} == {nh, nm, ns})
                            tick_d = 1'b1;
                        else if ({h_f[5:0], m_f[5:0], s_f[5:0]} != {hour_q, min_q, sec_q})
                            jump_d = 1'b1;
                    end
                end else begin
                    state_d     = FAULT;
                    valid_d     = 1'b0;
                    fault_d     = 1'b1;
                    err_field_d = bad;
                    err_count_d = (&err_count_q) ? err_count_q : err_count_q + ERR_W'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            snap_q      <= '1;
            cnt_q       <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            valid_q     <= 1'b0;
            tick_q      <= 1'b0;
            jump_q      <= 1'b0;
            fault_q     <= 1'b0;
            err_field_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            valid_q     <= valid_d;
            tick_q      <= tick_d;
            jump_q      <= jump_d;
            fault_q     <= fault_d;
            err_field_q <= err_field_d;
            err_count_q <= err_count_d;
        end
    end

    assign hour      = hour_q;
    assign min       = min_q;
    assign sec       = sec_q;
    assign valid     = valid_q;
    assign tick      = tick_q;
    assign jump      = jump_q;
    assign fault     = fault_q;
    assign err_field = err_field_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_seg_time_decoder.sv
// tb/tb_seg_time_decoder.sv - self-checking bench for seg_time_decoder
module tb_seg_time_decoder;
    localparam int S  = 4;
    localparam int EW = 8;

    logic          clk;
    logic          reset;
    logic [13:0]   hrsSeg, minsSeg, secsSeg;
    logic [5:0]    hour, min, sec;
    logic          valid, tick, jump, fault;
    logic [2:0]    err_field;
    logic [EW-1:0] err_count;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    // Reference model: committed time kept as plain numbers, settling tracked as edges since presentation.
    int          m_h, m_m, m_s, m_ec, m_age;
    bit          m_valid, m_tick, m_jump, m_fault;
    logic [2:0]  m_ef;
    logic [41:0] m_last;

    seg_time_decoder #(.STABLE_CYCLES(S), .ERR_W(EW)) dut (
        .clk(clk), .reset(reset), .hrsSeg(hrsSeg), .minsSeg(minsSeg), .secsSeg(secsSeg),
        .hour(hour), .min(min), .sec(sec), .valid(valid), .tick(tick), .jump(jump),
        .fault(fault), .err_field(err_field), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [13:0] enc(input int v);
        logic [13:0] r;
        r = {seg_tab[v / 10], seg_tab[v % 10]};
        return r;
    endfunction

    function automatic int dig(input logic [6:0] c);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == c) return i;
        return -1;
    endfunction

    function automatic int fld(input logic [13:0] w, input int maxv);
        int t, o;
        t = dig(w[13:7]);
        o = dig(w[6:0]);
        if (t < 0 || o < 0) return -1;
        if (t * 10 + o > maxv) return -1;
        return t * 10 + o;
    endfunction

    task automatic model_commit(input logic [41:0] w);
        int h, m, s, nt, ot;
        h = fld(w[41:28], 23);
        m = fld(w[27:14], 59);
        s = fld(w[13:0], 59);
        if (h >= 0 && m >= 0 && s >= 0) begin
            nt = h * 3600 + m * 60 + s;
            ot = m_h * 3600 + m_m * 60 + m_s;
            if (m_valid) begin
                if (nt == (ot + 1) % 86400) m_tick = 1;
                else if (nt != ot)         m_jump = 1;
            end
            m_h = h; m_m = m; m_s = s;
            m_valid = 1; m_fault = 0;
        end else begin
            m_valid = 0;
            m_fault = 1;
            m_ef    = {h < 0, m < 0, s < 0};
            if (m_ec < 255) m_ec++;
        end
    endtask

    task automatic model_edge(input logic r, input logic [41:0] w);
        m_tick = 0;
        m_jump = 0;
        if (r) begin
            m_last = '1; m_age = S + 1;
            m_h = 0; m_m = 0; m_s = 0; m_ec = 0; m_ef = 0;
            m_valid = 0; m_fault = 0;
        end else if (w != m_last) begin
            m_last = w;
            m_age  = 0;
        end else if (m_age < S) begin
            m_age++;
            if (m_age == S) model_commit(w);
        end
    endtask

    function automatic logic [32:0] outs();
        return {hour, min, sec, valid, tick, jump, fault, err_field, err_count};
    endfunction

    function automatic logic [32:0] expv();
        return {6'(m_h), 6'(m_m), 6'(m_s), m_valid, m_tick, m_jump, m_fault, m_ef, 8'(m_ec)};
    endfunction

    task automatic step(input logic r, input logic [13:0] h, input logic [13:0] m, input logic [13:0] s);
        @(negedge clk);
        reset = r; hrsSeg = h; minsSeg = m; secsSeg = s;
        @(posedge clk);
        model_edge(r, {h, m, s});
        #1;
    endtask

    task automatic test_reset();
        step(1, enc(12), enc(34), enc(56));
        step(1, enc(12), enc(34), enc(56));
        total++;
        if (outs() !== 33'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", outs(), 33'd0);
        end
        total++;
        if (outs() !== expv()) begin
            bad++; $display("FAIL reset_model got=%h exp=%h", outs(), expv());
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i <= S; i++) begin
            step(0, enc(12), enc(34), enc(56));
            total++;
            if (valid !== (i == S)) begin
                bad++; $display("FAIL lock_valid edge=%0d got=%b exp=%b", i, valid, i == S);
            end
            total++;
            if (outs() !== expv()) begin
                bad++; $display("FAIL lock_model edge=%0d got=%h exp=%h", i, outs(), expv());
            end
        end
        total++;
        if ({hour, min, sec, tick, jump} !== {6'd12, 6'd34, 6'd56, 2'b00}) begin
            bad++; $display("FAIL lock_time got=%0d:%0d:%0d t=%b j=%b exp=12:34:56 t=0 j=0",
                            hour, min, sec, tick, jump);
        end
    endtask

    task automatic test_tick();
        for (int i = 0; i <= S; i++) step(0, enc(12), enc(34), enc(57));
        total++;
        if ({tick, jump, sec} !== {2'b10, 6'd57}) begin
            bad++; $display("FAIL tick_plus1 got t=%b j=%b s=%0d exp t=1 j=0 s=57", tick, jump, sec);
        end
        step(0, enc(12), enc(34), enc(57));
        total++;
        if ({tick, jump} !== 2'b00) begin
            bad++; $display("FAIL tick_one_cycle got t=%b j=%b exp t=0 j=0", tick, jump);
        end
        for (int i = 0; i <= S; i++) step(0, enc(23), enc(59), enc(59));
        for (int i = 0; i <= S; i++) step(0, enc(0), enc(0), enc(0));
        total++;
        if ({hour, min, sec, tick, jump} !== {18'd0, 2'b10}) begin
            bad++; $display("FAIL tick_wrap got=%0d:%0d:%0d t=%b j=%b exp=0:0:0 t=1 j=0",
                            hour, min, sec, tick, jump);
        end
        total++;
        if (outs() !== expv()) begin
            bad++; $display("FAIL tick_model got=%h exp=%h", outs(), expv());
        end
    endtask

    task automatic test_jump_glitch();
        for (int i = 0; i <= S; i++) step(0, enc(12), enc(34), enc(57));
        for (int i = 0; i <= S; i++) step(0, enc(5), enc(0), enc(0));
        total++;
        if ({hour, min, sec, tick, jump} !== {6'd5, 12'd0, 2'b01}) begin
            bad++; $display("FAIL jump_pulse got=%0d:%0d:%0d t=%b j=%b exp=5:0:0 t=0 j=1",
                            hour, min, sec, tick, jump);
        end
        for (int i = 0; i <= S + 1; i++) step(0, enc(12), enc(34), enc(57));
        for (int i = 0; i < 3 + S + 2; i++) begin
            if (i < 3) step(0, enc(12), enc(34), enc(58));
            else       step(0, enc(12), enc(34), enc(57));
            total++;
            if ({hour, min, sec, tick, jump, valid} !== {6'd12, 6'd34, 6'd57, 3'b001}) begin
                bad++; $display("FAIL glitch_hold cyc=%0d got=%0d:%0d:%0d t=%b j=%b v=%b",
                                i, hour, min, sec, tick, jump, valid);
            end
        end
    endtask

    task automatic test_fault_recovery();
        for (int i = 0; i <= S; i++) step(0, enc(12), enc(34), {seg_tab[5], 7'h7f});
        total++;
        if ({fault, valid, err_field, err_count, hour, min, sec} !==
            {2'b10, 3'b001, 8'd1, 6'd12, 6'd34, 6'd57}) begin
            bad++; $display("FAIL fault_blank got f=%b v=%b ef=%b ec=%0d %0d:%0d:%0d",
                            fault, valid, err_field, err_count, hour, min, sec);
        end
        for (int i = 0; i <= S; i++) step(0, enc(12), enc(35), enc(0));
        total++;
        if ({valid, fault, tick, jump, hour, min, sec} !== {4'b1000, 6'd12, 6'd35, 6'd0}) begin
            bad++; $display("FAIL fault_recover got v=%b f=%b t=%b j=%b %0d:%0d:%0d",
                            valid, fault, tick, jump, hour, min, sec);
        end
    endtask

    task automatic test_range_saturate();
        step(1, enc(0), enc(0), enc(0));
        for (int i = 0; i <= S; i++) step(0, enc(24), enc(0), enc(0));
        total++;
        if ({fault, err_field, err_count} !== {1'b1, 3'b100, 8'd1}) begin
            bad++; $display("FAIL range_hours got f=%b ef=%b ec=%0d exp f=1 ef=100 ec=1",
                            fault, err_field, err_count);
        end
        for (int i = 0; i <= S; i++) step(0, enc(12), enc(60), enc(0));
        total++;
        if ({fault, err_field, err_count} !== {1'b1, 3'b010, 8'd2}) begin
            bad++; $display("FAIL range_mins got f=%b ef=%b ec=%0d exp f=1 ef=010 ec=2",
                            fault, err_field, err_count);
        end
        for (int k = 0; k < 260; k++) begin
            for (int i = 0; i <= S; i++) begin
                if (k % 2 == 0) step(0, enc(24), enc(0), enc(0));
                else            step(0, enc(12), enc(60), enc(0));
            end
            total++;
            if (outs() !== expv()) begin
                bad++; $display("FAIL sat_model k=%0d got=%h exp=%h", k, outs(), expv());
            end
        end
        total++;
        if (err_count !== 8'hff) begin
            bad++; $display("FAIL sat_count got=%0d exp=255", err_count);
        end
    endtask

    task automatic test_reset_mid_settle();
        for (int i = 0; i <= S; i++) step(0, enc(1), enc(2), enc(3));
        step(0, enc(1), enc(2), enc(4));
        step(0, enc(1), enc(2), enc(4));
        step(1, enc(1), enc(2), enc(4));
        total++;
        if (outs() !== 33'd0) begin
            bad++; $display("FAIL midreset_outputs got=%h exp=%h", outs(), 33'd0);
        end
        for (int i = 0; i <= S; i++) begin
            step(0, enc(1), enc(2), enc(4));
            total++;
            if ({valid, tick, jump} !== {i == S, 2'b00}) begin
                bad++; $display("FAIL midreset_relock edge=%0d got v=%b t=%b j=%b exp v=%b",
                                i, valid, tick, jump, i == S);
            end
        end
        total++;
        if ({hour, min, sec} !== {6'd1, 6'd2, 6'd4}) begin
            bad++; $display("FAIL midreset_time got=%0d:%0d:%0d exp=1:2:4", hour, min, sec);
        end
    endtask

    task automatic test_random();
        int t, hold, mode;
        logic [13:0] h, m, s;
        t = 0;
        for (int n = 0; n < 300; n++) begin
            mode = $urandom_range(0, 5);
            if (mode <= 2) t = (t + 1) % 86400;
            else if (mode == 3) t = $urandom_range(0, 86399);
            h = enc(t / 3600); m = enc((t / 60) % 60); s = enc(t % 60);
            if (mode == 4) begin
                h = enc($urandom_range(0, 99)); m = enc($urandom_range(0, 99));
            end else if (mode == 5) begin
                s = 14'($urandom);
            end
            hold = $urandom_range(1, S + 3);
            for (int i = 0; i < hold; i++) begin
                step(0, h, m, s);
                total++;
                if (outs() !== expv()) begin
                    bad++; $display("FAIL random_model n=%0d i=%0d got=%h exp=%h", n, i, outs(), expv());
                end
            end
        end
    endtask

    initial begin
        clk = 0; reset = 1;
        hrsSeg = '0; minsSeg = '0; secsSeg = '0;
        m_last = '1; m_age = S + 1; m_h = 0; m_m = 0; m_s = 0; m_ec = 0; m_ef = 0;
        m_valid = 0; m_tick = 0; m_jump = 0; m_fault = 0;
        test_reset();
        test_lock();
        test_tick();
        test_jump_glitch();
        test_fault_recovery();
        test_range_saturate();
        test_reset_mid_settle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_time_decoder.md
Name: seg_time_decoder

Overview:
- Sits on the far side of the clock's display bus: samples the three 14-bit two-digit seven-segment words (hours, minutes, seconds) and recovers binary time.
- Filters bus transitions for stability, checks legality and range, flags faults, and reports per-second ticks versus discontinuous jumps.
- Serves as the readback/self-check path for the display encoder and as a time source for downstream logic.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a snapshot is evaluated; legal range ≥1.
- ERR_W, 8: width of the saturating fault counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; sampled on posedge clk
- hrsSeg  in  14  hours display word
- minsSeg  in  14  minutes display word
- secsSeg  in  14  seconds display word
- hour  out  6  decoded hours, binary, 0..23
- min  out  6  decoded minutes, binary, 0..59
- sec  out  6  decoded seconds, binary, 0..59
- valid  out  1  hour/min/sec hold a committed legal time
- tick  out  1  one-cycle pulse: committed time advanced by exactly one second
- jump  out  1  one-cycle pulse: committed time changed by anything other than +1 s
- fault  out  1  high while the stable snapshot is illegal
- err_field  out  3  illegal fields latched at fault entry: bit2 hours, bit1 minutes, bit0 seconds
- err_count  out  ERR_W  saturating count of fault entries

Behaviour:
- Word format: [13:7] is the tens digit and [6:0] is the ones digit. Each 7-bit field is active-low, bit0=a through bit6=g.
- Legal digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000. Any other code is illegal, including blank 1111111.
- Range check: hours tens ≤2 and value ≤23; minutes and seconds tens ≤5.
- A field is illegal if either digit code is illegal or the value is out of range.
- Reset: snapshot ← all ones, stability counter ← 0, state IDLE. Outputs: hour=min=sec=0, valid=0, tick=0, jump=0, fault=0, err_field=0, err_count=0. Reset has priority over everything, including mid-settle.
- Snapshot rule, evaluated each edge with in = {hrsSeg, minsSeg, secsSeg}:
  - If in ≠ snapshot: snapshot ← in, counter ← 0, state ← SETTLE.
  - Otherwise, in SETTLE: if counter == STABLE_CYCLES−1, evaluate the snapshot; else counter ← counter+1.
- Latency: with a new value first presented before edge e0, the commit takes effect at edge e0+STABLE_CYCLES, provided the input is held. Any change before then restarts settling.
- States:
  - IDLE: after reset, valid=0; the first edge always enters SETTLE because the snapshot reset value is illegal.
  - SETTLE: counting stability; all outputs hold.
  - LOCKED: legal time committed.
  - FAULT: stable illegal snapshot.
  - Any state → SETTLE on input change.
- Evaluating a legal snapshot:
  - hour/min/sec ← decoded values, valid ← 1, fault ← 0, state LOCKED.
  - If valid was 1 before the commit: tick=1 if new time == old time + 1 s, with carries and 23:59:59→00:00:00 wrap; else jump=1 if new ≠ old; neither if equal.
  - If valid was 0 (first lock, or recovery from fault): no pulse.
- Evaluating an illegal snapshot:
  - state FAULT, valid ← 0, fault ← 1, err_field ← per-field illegal flags, err_count ← err_count+1, saturating at all ones.
  - hour/min/sec hold their last committed values.
- tick and jump are high for exactly the one cycle after the commit edge, are never both high, and are 0 otherwise.
- Re-entering SETTLE does not clear valid or fault; only an evaluation changes them.

Test Plan:
- Reset, then hold 12:34:56 → at edge 4 after first presentation: hour=12, min=34, sec=56, valid=1, tick=0, jump=0; valid=0 on edges 1..3.
- From locked 12:34:56, present 12:34:57 → tick=1 for one cycle after 4 edges, jump=0. Repeat 23:59:59→00:00:00 → tick=1, outputs 0/0/0.
- From locked 12:34:57, present 05:00:00 → jump=1 once, tick=0. A 3-cycle glitch to 12:34:58, then back to 12:34:57 → no commit, no pulse, outputs unchanged.
- secsSeg ones field = 1111111 held → fault=1, valid=0, err_field=001, err_count=1, hour/min/sec unchanged. Then present a legal 12:35:00 → valid=1, fault=0, no tick or jump.
- hrsSeg = "24", then minsSeg = "60" in separate events → two faults with err_field=100 then 010, err_count=2. Force 255 fault entries → err_count stays 255.
- Assert reset two cycles into SETTLE → all outputs return to reset values; the next stable legal word takes a full STABLE_CYCLES to commit.
